// File: rtl/zero_count_frame_accum_if.sv
// Stream interface for the frame accumulator: per-byte zero-count beats in,
// one frame result out. The accumulator uses the slave view.
interface zero_count_frame_accum_if #(
   parameter int SUM_W = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       in_count;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [SUM_W-1:0] out_sum;
   logic [7:0]       out_bytes;
   logic             err_cnt;
   logic             err_len;

   modport master (
      output in_valid, in_count, in_last, out_ready,
      input  in_ready, out_valid, out_sum, out_bytes, err_cnt, err_len
   );

   modport slave (
      input  in_valid, in_count, in_last, out_ready,
      output in_ready, out_valid, out_sum, out_bytes, err_cnt, err_len
   );
endinterface

// File: rtl/zero_count_frame_accum.sv
// Sums per-byte zero counts over a frame and presents one registered result
// per frame (sum, byte count, error flags) behind a valid/ready handshake.
module zero_count_frame_accum #(
   parameter int MAX_BYTES = 16,
   parameter int SUM_W     = 8
) (
   input logic                    clk,
   input logic                    rst_n,
   zero_count_frame_accum_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_e;

   localparam logic [7:0] MAXB = 8'(MAX_BYTES);

   state_e           state_q, state_d;
   logic [SUM_W-1:0] sum_q, sum_d, out_sum_q, out_sum_d;
   logic [7:0]       bytes_q, bytes_d, out_bytes_q, out_bytes_d;
   logic             errc_q, errc_d;
   logic             out_valid_q, out_valid_d;
   logic             out_errc_q, out_errc_d, out_errl_q, out_errl_d;

   logic             accept, close, over;
   logic [3:0]       c;
   logic [SUM_W-1:0] nsum;
   logic [7:0]       nbytes;
   logic             nerrc;

   assign bus.in_ready  = (state_q != HOLD);
   assign bus.out_valid = out_valid_q;
   assign bus.out_sum   = out_sum_q;
   assign bus.out_bytes = out_bytes_q;
   assign bus.err_cnt   = out_errc_q;
   assign bus.err_len   = out_errl_q;

   always_comb begin
      accept = bus.in_valid && (state_q != HOLD);
      over   = bus.in_count > 4'd8;
      c      = over ? 4'd8 : bus.in_count;
      // IDLE starts a fresh frame regardless of stale accumulator contents
      nsum   = ((state_q == ACCUM) ? sum_q : '0) + SUM_W'(c);
      nbytes = ((state_q == ACCUM) ? bytes_q : 8'd0) + 8'd1;
      nerrc  = ((state_q == ACCUM) && errc_q) || over;
      close  = accept && (bus.in_last || (nbytes == MAXB));

      state_d     = state_q;
      sum_d       = sum_q;
      bytes_d     = bytes_q;
      errc_d      = errc_q;
      out_valid_d = out_valid_q;
      out_sum_d   = out_sum_q;
      out_bytes_d = out_bytes_q;
      out_errc_d  = out_errc_q;
      out_errl_d  = out_errl_q;

      case (state_q)
         IDLE, ACCUM: begin
            if (accept) begin
               sum_d   = nsum;
               bytes_d = nbytes;
               errc_d  = nerrc;
               if (close) begin
                  state_d     = HOLD;
                  out_valid_d = 1'b1;
                  out_sum_d   = nsum;
                  out_bytes_d = nbytes;
                  out_errc_d  = nerrc;
                  out_errl_d  = !bus.in_last;
               end else begin
                  state_d = ACCUM;
               end
            end
         end
         HOLD: begin
            if (bus.out_ready) begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
               sum_d       = '0;
               bytes_d     = 8'd0;
               errc_d      = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         sum_q       <= '0;
         bytes_q     <= 8'd0;
         errc_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_sum_q   <= '0;
         out_bytes_q <= 8'd0;
         out_errc_q  <= 1'b0;
         out_errl_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         sum_q       <= sum_d;
         bytes_q     <= bytes_d;
         errc_q      <= errc_d;
         out_valid_q <= out_valid_d;
         out_sum_q   <= out_sum_d;
         out_bytes_q <= out_bytes_d;
         out_errc_q  <= out_errc_d;
         out_errl_q  <= out_errl_d;
      end
   end
endmodule
